// File: rtl/encoder_pkg.sv
// encoder_pkg: constants and types shared across the HardwareEncoder LPC path.
package encoder_pkg;

    localparam int MAX_ORDER = 32;

    localparam logic [31:0] FLOAT_ZERO = 32'h00000000;
    localparam logic [31:0] FLOAT_ONE  = 32'h3f800000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/operand_store.sv
// operand_store: register file with one write port and two combinational
// read ports. Contents are intentionally not reset. Addresses at or beyond
// DEPTH are dropped on write and read back as zero.
module operand_store #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              iClock,
    input  logic              iWrite,
    input  logic [ADDR_W-1:0] iWriteAddr,
    input  logic [DATA_W-1:0] iWriteData,
    input  logic [ADDR_W-1:0] iReadAddr1,
    input  logic [ADDR_W-1:0] iReadAddr2,
    output logic [DATA_W-1:0] oReadData1,
    output logic [DATA_W-1:0] oReadData2
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_writeInRange;
    logic w_read1InRange;
    logic w_read2InRange;

    assign w_writeInRange = ({1'b0, iWriteAddr} < DEPTH_A);
    assign w_read1InRange = ({1'b0, iReadAddr1} < DEPTH_A);
    assign w_read2InRange = ({1'b0, iReadAddr2} < DEPTH_A);

    // Store a word when the strobe is up and the address lands inside the file.
    always_ff @(posedge iClock) begin
        if (iWrite && w_writeInRange) begin
            r_mem[iWriteAddr[IDX_W-1:0]] <= iWriteData;
        end
    end

    // Two independent read ports; out-of-range reads return zero.
    always_comb begin
        oReadData1 = '0;
        oReadData2 = '0;
        if (w_read1InRange) begin
            oReadData1 = r_mem[iReadAddr1[IDX_W-1:0]];
        end
        if (w_read2InRange) begin
            oReadData2 = r_mem[iReadAddr2[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/alpha_operand_sequencer.sv
// alpha_operand_sequencer: holds the ACF and model vectors, streams
// {acf[m-k], model[k]} term pairs to the AlphaCalculator two per cycle,
// then captures the returned alpha word and reports it upstream.
module alpha_operand_sequencer #(
    parameter int MAX_ORDER = encoder_pkg::MAX_ORDER,
    parameter int ADDR_W    = 6
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iEnable,
    input  logic              iACFWrite,
    input  logic [ADDR_W-1:0] iACFAddr,
    input  logic [31:0]       iACFData,
    input  logic              iModelWrite,
    input  logic [ADDR_W-1:0] iModelAddr,
    input  logic [31:0]       iModelData,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iOrder,
    output logic              oValid,
    output logic [31:0]       oACF1,
    output logic [31:0]       oACF2,
    output logic [31:0]       oModel1,
    output logic [31:0]       oModel2,
    input  logic              iAlphaDone,
    input  logic [31:0]       iAlpha,
    output logic [31:0]       oAlpha,
    output logic              oDone,
    output logic              oBusy
);

    import encoder_pkg::*;

    localparam logic [ADDR_W-1:0] MAX_ORDER_A = ADDR_W'(MAX_ORDER);
    localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);

    seq_state_t r_state;
    seq_state_t w_nextState;

    logic [ADDR_W-1:0] r_order;
    logic [ADDR_W-1:0] r_pair;
    logic [ADDR_W-1:0] r_pairCount;
    logic [31:0]       r_alpha;

    logic [ADDR_W-1:0] w_clampedOrder;
    logic [ADDR_W-1:0] w_startPairCount;
    logic              w_lastPair;
    logic              w_writeOpen;
    logic              w_acfWrite;
    logic              w_modelWrite;

    logic [ADDR_W-1:0] w_termEven;
    logic [ADDR_W-1:0] w_termOdd;
    logic [ADDR_W-1:0] w_acfAddr1;
    logic [ADDR_W-1:0] w_acfAddr2;
    logic              w_oddTermPresent;

    logic [31:0] w_acfRead1;
    logic [31:0] w_acfRead2;
    logic [31:0] w_modelRead1;
    logic [31:0] w_modelRead2;

    // Orders beyond the supported maximum run as a full-length sequence.
    assign w_clampedOrder   = (iOrder > MAX_ORDER_A) ? MAX_ORDER_A : iOrder;
    assign w_startPairCount = (w_clampedOrder + ONE_A) >> 1;
    assign w_lastPair       = (r_pair == (r_pairCount - ONE_A));

    // Storage only changes while idle, so an in-flight sequence reads a stable snapshot.
    assign w_writeOpen  = iEnable && (r_state == IDLE);
    assign w_acfWrite   = w_writeOpen && iACFWrite && (iACFAddr <= MAX_ORDER_A);
    assign w_modelWrite = w_writeOpen && iModelWrite && (iModelAddr < MAX_ORDER_A);

    // Pair j covers terms 2j and 2j+1; the ACF side walks downward from index m.
    assign w_termEven       = {r_pair[ADDR_W-2:0], 1'b0};
    assign w_termOdd        = {r_pair[ADDR_W-2:0], 1'b1};
    assign w_acfAddr1       = r_order - w_termEven;
    assign w_acfAddr2       = r_order - w_termOdd;
    assign w_oddTermPresent = (w_termOdd < r_order);

    operand_store #(
        .DEPTH  (MAX_ORDER + 1),
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_acfStore (
        .iClock     (iClock),
        .iWrite     (w_acfWrite),
        .iWriteAddr (iACFAddr),
        .iWriteData (iACFData),
        .iReadAddr1 (w_acfAddr1),
        .iReadAddr2 (w_acfAddr2),
        .oReadData1 (w_acfRead1),
        .oReadData2 (w_acfRead2)
    );

    operand_store #(
        .DEPTH  (MAX_ORDER),
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_modelStore (
        .iClock     (iClock),
        .iWrite     (w_modelWrite),
        .iWriteAddr (iModelAddr),
        .iWriteData (iModelData),
        .iReadAddr1 (w_termEven),
        .iReadAddr2 (w_termOdd),
        .oReadData1 (w_modelRead1),
        .oReadData2 (w_modelRead2)
    );

    // State register; a low enable freezes the sequencer where it stands.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= IDLE;
        end else if (iEnable) begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a zero-order start skips straight to reporting.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (iStart) begin
                    w_nextState = (w_clampedOrder == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (w_lastPair) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (iAlphaDone) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Sequence bookkeeping: latch the order on start, step pairs, capture alpha.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_order     <= '0;
            r_pair      <= '0;
            r_pairCount <= '0;
            r_alpha     <= FLOAT_ZERO;
        end else if (iEnable) begin
            case (r_state)
                IDLE: begin
                    if (iStart) begin
                        r_order     <= w_clampedOrder;
                        r_pairCount <= w_startPairCount;
                        r_pair      <= '0;
                        if (w_clampedOrder == '0) begin
                            r_alpha <= FLOAT_ZERO;
                        end
                    end
                end
                ISSUE: begin
                    if (!w_lastPair) begin
                        r_pair <= r_pair + ONE_A;
                    end
                end
                WAIT: begin
                    if (iAlphaDone) begin
                        r_alpha <= iAlpha;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operand outputs follow the current pair while issuing and rest at zero otherwise.
    always_comb begin
        oACF1   = FLOAT_ZERO;
        oACF2   = FLOAT_ZERO;
        oModel1 = FLOAT_ZERO;
        oModel2 = FLOAT_ZERO;
        if (r_state == ISSUE) begin
            oACF1   = w_acfRead1;
            oModel1 = w_modelRead1;
            if (w_oddTermPresent) begin
                oACF2   = w_acfRead2;
                oModel2 = w_modelRead2;
            end
        end
    end

    assign oValid = iEnable && (r_state == ISSUE);
    assign oDone  = iEnable && (r_state == DONE);
    assign oBusy  = (r_state != IDLE);
    assign oAlpha = r_alpha;

endmodule

// File: tb/tb_alpha_operand_sequencer.sv
// tb_alpha_operand_sequencer: directed self-checking bench for the operand sequencer.
module tb_alpha_operand_sequencer;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iEnable;
    logic        iACFWrite;
    logic [5:0]  iACFAddr;
    logic [31:0] iACFData;
    logic        iModelWrite;
    logic [5:0]  iModelAddr;
    logic [31:0] iModelData;
    logic        iStart;
    logic [5:0]  iOrder;
    logic        oValid;
    logic [31:0] oACF1;
    logic [31:0] oACF2;
    logic [31:0] oModel1;
    logic [31:0] oModel2;
    logic        iAlphaDone;
    logic [31:0] iAlpha;
    logic [31:0] oAlpha;
    logic        oDone;
    logic        oBusy;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] acfMem   [0:32];
    logic [31:0] modelMem [0:31];
    logic [31:0] seenACF1   [0:15];
    logic [31:0] seenACF2   [0:15];
    logic [31:0] seenModel1 [0:15];
    logic [31:0] seenModel2 [0:15];

    alpha_operand_sequencer dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iEnable     (iEnable),
        .iACFWrite   (iACFWrite),
        .iACFAddr    (iACFAddr),
        .iACFData    (iACFData),
        .iModelWrite (iModelWrite),
        .iModelAddr  (iModelAddr),
        .iModelData  (iModelData),
        .iStart      (iStart),
        .iOrder      (iOrder),
        .oValid      (oValid),
        .oACF1       (oACF1),
        .oACF2       (oACF2),
        .oModel1     (oModel1),
        .oModel2     (oModel2),
        .iAlphaDone  (iAlphaDone),
        .iAlpha      (iAlpha),
        .oAlpha      (oAlpha),
        .oDone       (oDone),
        .oBusy       (oBusy)
    );

    always #5 iClock = ~iClock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %08h, expected %08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    // Raw one-cycle write strobe into either store, no bookkeeping.
    task automatic applyStimulus(input logic isModel, input logic [5:0] addr,
                                 input logic [31:0] data);
        if (isModel) begin
            iModelWrite = 1'b1;
            iModelAddr  = addr;
            iModelData  = data;
        end else begin
            iACFWrite = 1'b1;
            iACFAddr  = addr;
            iACFData  = data;
        end
        tick();
        iModelWrite = 1'b0;
        iACFWrite   = 1'b0;
    endtask

    task automatic writeACF(input int idx, input logic [31:0] data);
        applyStimulus(1'b0, 6'(idx), data);
        acfMem[idx] = data;
    endtask

    task automatic writeModel(input int idx, input logic [31:0] data);
        applyStimulus(1'b1, 6'(idx), data);
        modelMem[idx] = data;
    endtask

    // Start a sequence and follow it to oDone, checking every issued pair,
    // the pair count, the completion latency and the captured alpha.
    task automatic runSequence(input logic [5:0] order, input logic [31:0] alpha,
                               input int stallAt, input bit busyPoke, input string tag);
        int m;
        int pairs;
        int pairIdx;
        int doneSeen;
        int doneCycle;
        int expDoneCycle;
        int k1;
        int k2;
        bit alphaSent;
        logic [31:0] expAlpha;
        logic [31:0] expA1;
        logic [31:0] expA2;
        logic [31:0] expM1;
        logic [31:0] expM2;

        m            = (order > 6'd32) ? 32 : int'(order);
        pairs        = (m + 1) / 2;
        expAlpha     = (m == 0) ? 32'h0 : alpha;
        expDoneCycle = (m == 0) ? 1 : pairs + 2 + ((stallAt > 0) ? 3 : 0);
        pairIdx      = 0;
        doneSeen     = 0;
        doneCycle    = 0;
        alphaSent    = (m == 0);

        iEnable = 1'b1;
        iOrder  = order;
        iStart  = 1'b1;
        tick();
        iStart = 1'b0;

        for (int cyc = 1; cyc < 60 && doneSeen == 0; cyc++) begin
            iEnable     = !(stallAt > 0 && cyc >= stallAt && cyc < stallAt + 3);
            iAlphaDone  = 1'b0;
            iStart      = 1'b0;
            iModelWrite = 1'b0;
            if (busyPoke && cyc == 1) begin
                iStart      = 1'b1;
                iOrder      = 6'd1;
                iModelWrite = 1'b1;
                iModelAddr  = 6'd0;
                iModelData  = 32'hdeadbeef;
            end
            if (!alphaSent && pairIdx == pairs) begin
                iAlphaDone = 1'b1;
                iAlpha     = alpha;
                alphaSent  = 1'b1;
            end
            #1;
            if (cyc == 1) begin
                checkOutput($sformatf("%s.busyAfterStart", tag), 32'(oBusy), 32'd1);
            end
            if (oValid) begin
                if (pairIdx < pairs) begin
                    k1    = 2 * pairIdx;
                    k2    = k1 + 1;
                    expA1 = (k1 < m) ? acfMem[m - k1] : 32'h0;
                    expM1 = (k1 < m) ? modelMem[k1]   : 32'h0;
                    expA2 = (k2 < m) ? acfMem[m - k2] : 32'h0;
                    expM2 = (k2 < m) ? modelMem[k2]   : 32'h0;
                    checkOutput($sformatf("%s.pair%0d.acf1", tag, pairIdx), oACF1, expA1);
                    checkOutput($sformatf("%s.pair%0d.model1", tag, pairIdx), oModel1, expM1);
                    checkOutput($sformatf("%s.pair%0d.acf2", tag, pairIdx), oACF2, expA2);
                    checkOutput($sformatf("%s.pair%0d.model2", tag, pairIdx), oModel2, expM2);
                    seenACF1[pairIdx]   = oACF1;
                    seenACF2[pairIdx]   = oACF2;
                    seenModel1[pairIdx] = oModel1;
                    seenModel2[pairIdx] = oModel2;
                end
                pairIdx++;
            end
            if (oDone) begin
                doneSeen  = 1;
                doneCycle = cyc;
                checkOutput($sformatf("%s.alpha", tag), oAlpha, expAlpha);
            end
            tick();
        end

        iEnable     = 1'b1;
        iAlphaDone  = 1'b0;
        iStart      = 1'b0;
        iModelWrite = 1'b0;
        checkOutput($sformatf("%s.validCount", tag), 32'(pairIdx), 32'(pairs));
        checkOutput($sformatf("%s.doneSeen", tag), 32'(doneSeen), 32'd1);
        checkOutput($sformatf("%s.doneCycle", tag), 32'(doneCycle), 32'(expDoneCycle));
        #1;
        checkOutput($sformatf("%s.donePulseEnds", tag), 32'(oDone), 32'd0);
        checkOutput($sformatf("%s.idleAfterDone", tag), 32'(oBusy), 32'd0);
        tick();
    endtask

    initial begin
        iReset      = 1'b1;
        iEnable     = 1'b1;
        iACFWrite   = 1'b0;
        iACFAddr    = '0;
        iACFData    = '0;
        iModelWrite = 1'b0;
        iModelAddr  = '0;
        iModelData  = '0;
        iStart      = 1'b0;
        iOrder      = '0;
        iAlphaDone  = 1'b0;
        iAlpha      = '0;
        for (int i = 0; i <= 32; i++) acfMem[i] = 32'h0;
        for (int i = 0; i < 32; i++) modelMem[i] = 32'h0;

        tick();
        tick();
        checkOutput("reset.valid", 32'(oValid), 32'd0);
        checkOutput("reset.done", 32'(oDone), 32'd0);
        checkOutput("reset.busy", 32'(oBusy), 32'd0);
        checkOutput("reset.acf1", oACF1, 32'h0);
        checkOutput("reset.model2", oModel2, 32'h0);
        checkOutput("reset.alpha", oAlpha, 32'h0);
        iReset = 1'b0;
        tick();

        $display("[TB] test 1: m=2 single pair");
        writeACF(2, 32'hbf000000);
        writeModel(0, 32'h40000000);
        writeACF(1, 32'h3f000000);
        writeModel(1, 32'h40800000);
        runSequence(6'd2, 32'h3f800000, 0, 1'b0, "t1");
        checkOutput("t1.hand.acf1", seenACF1[0], 32'hbf000000);
        checkOutput("t1.hand.model1", seenModel1[0], 32'h40000000);
        checkOutput("t1.hand.acf2", seenACF2[0], 32'h3f000000);
        checkOutput("t1.hand.model2", seenModel2[0], 32'h40800000);
        checkOutput("t1.alphaHeld", oAlpha, 32'h3f800000);

        $display("[TB] test 2: m=3 odd order");
        writeACF(3, 32'hc0400000);
        writeModel(2, 32'h41000000);
        runSequence(6'd3, 32'h40400000, 0, 1'b0, "t2");
        checkOutput("t2.hand.pair0.acf1", seenACF1[0], 32'hc0400000);
        checkOutput("t2.hand.pair1.acf1", seenACF1[1], 32'h3f000000);
        checkOutput("t2.hand.pair1.model1", seenModel1[1], 32'h41000000);
        checkOutput("t2.hand.pair1.acf2", seenACF2[1], 32'h00000000);
        checkOutput("t2.hand.pair1.model2", seenModel2[1], 32'h00000000);

        $display("[TB] test 3: m=0");
        runSequence(6'd0, 32'h55555555, 0, 1'b0, "t3");

        $display("[TB] test 4: m=8 with a 3-cycle stall");
        for (int i = 4; i <= 8; i++) writeACF(i, 32'h40000000 + (32'(i) << 16));
        for (int i = 3; i <= 7; i++) writeModel(i, 32'h3e000000 + (32'(i) << 16));
        runSequence(6'd8, 32'h3fc00000, 2, 1'b0, "t4");
        checkOutput("t4.hand.pair0.acf1", seenACF1[0], 32'h40080000);
        checkOutput("t4.hand.pair3.model2", seenModel2[3], 32'h3e070000);

        $display("[TB] test 5: reset during WAIT");
        iOrder = 6'd2;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        tick();
        checkOutput("t5.busyInWait", 32'(oBusy), 32'd1);
        checkOutput("t5.alphaBefore", oAlpha, 32'h3fc00000);
        iReset = 1'b1;
        #1;
        checkOutput("t5.busyCleared", 32'(oBusy), 32'd0);
        checkOutput("t5.alphaCleared", oAlpha, 32'h0);
        tick();
        iReset     = 1'b0;
        iAlphaDone = 1'b1;
        iAlpha     = 32'h12345678;
        tick();
        iAlphaDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t5.noDone%0d", i), 32'(oDone), 32'd0);
            checkOutput($sformatf("t5.alphaZero%0d", i), oAlpha, 32'h0);
            checkOutput($sformatf("t5.notBusy%0d", i), 32'(oBusy), 32'd0);
            tick();
        end

        $display("[TB] test 6: start and write while busy");
        runSequence(6'd3, 32'h3f000000, 0, 1'b1, "t6poke");
        runSequence(6'd3, 32'h3e800000, 0, 1'b0, "t6rerun");
        checkOutput("t6.model0Kept", seenModel1[0], 32'h40000000);

        $display("[TB] test 7: order clamp and out-of-range writes");
        for (int i = 0; i <= 32; i++) writeACF(i, 32'h41000000 | 32'(i));
        for (int i = 0; i < 32; i++) writeModel(i, 32'hc1000000 | (32'(i) << 8));
        applyStimulus(1'b1, 6'd32, 32'hbadbad00);
        applyStimulus(1'b0, 6'd33, 32'hbadbad11);
        runSequence(6'd40, 32'h40a00000, 0, 1'b0, "t7");
        checkOutput("t7.hand.pair0.acf1", seenACF1[0], 32'h41000020);
        checkOutput("t7.hand.pair0.model1", seenModel1[0], 32'hc1000000);
        checkOutput("t7.hand.pair15.model2", seenModel2[15], 32'hc1001f00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
